// File: rtl/demux_pkg.sv
// Shared constants and FSM state type for the 1-to-8 TDM demultiplexer.
package demux_pkg;
   localparam int NUM_SLOTS = 8;
   localparam int SLOT_W    = 3;

   typedef enum logic {
      HUNT = 1'b0,
      RUN  = 1'b1
   } state_t;
endpackage

// File: rtl/tdm_slot_cnt.sv
// Modulo-8 slot counter: clear beats load-to-1, which beats increment.
// Updates on the edge after its control inputs; no flow control of its own.
module tdm_slot_cnt
   import demux_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              load1,
   input  logic              clr,
   output logic [SLOT_W-1:0] cnt
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (load1) begin
         cnt <= SLOT_W'(1);
      end else if (en) begin
         cnt <= cnt + SLOT_W'(1);
      end
   end

endmodule

// File: rtl/demux_1to8_tdm.sv
// Splits a TDM slot stream into an 8-wide frame; y/valid appear one cycle after slot 7.
// en=0 freezes all state; DEMUX_SYNC_CHECK_EN adds misplaced-frame-marker resync.
module demux_1to8_tdm
   import demux_pkg::*;
#(
   parameter int W = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              frame,
   input  logic [W-1:0]      din,
   output logic [W-1:0]      y0,
   output logic [W-1:0]      y1,
   output logic [W-1:0]      y2,
   output logic [W-1:0]      y3,
   output logic [W-1:0]      y4,
   output logic [W-1:0]      y5,
   output logic [W-1:0]      y6,
   output logic [W-1:0]      y7,
   output logic              valid,
   output logic [SLOT_W-1:0] sel,
   output logic              locked,
   output logic              sync_err
);

   localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_SLOTS - 1);

   state_t            state;
   state_t            state_nxt;
   logic              cnt_en;
   logic              cnt_load1;
   logic              cnt_clr;
   logic              shadow_wr;
   logic [SLOT_W-1:0] wr_idx;
   logic              frame_done;
   logic              resync;

   // Slot 7 never needs a shadow: it goes straight from din to y7.
   logic [W-1:0] shadow [0:NUM_SLOTS-2];

   tdm_slot_cnt u_slot_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (cnt_en),
      .load1 (cnt_load1),
      .clr   (cnt_clr),
      .cnt   (sel)
   );

`ifdef DEMUX_SYNC_CHECK_EN
   assign resync = (state == RUN) && en && frame && (sel != '0);
`else
   assign resync = 1'b0;
`endif

   always_comb begin
      state_nxt  = state;
      cnt_en     = 1'b0;
      cnt_load1  = 1'b0;
      cnt_clr    = 1'b0;
      shadow_wr  = 1'b0;
      wr_idx     = sel;
      frame_done = 1'b0;
      case (state)
         HUNT: begin
            cnt_clr = 1'b1;
            wr_idx  = '0;
            if (en && frame) begin
               cnt_clr   = 1'b0;
               cnt_load1 = 1'b1;
               shadow_wr = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            if (en) begin
               if (resync) begin
                  cnt_load1 = 1'b1;
                  shadow_wr = 1'b1;
                  wr_idx    = '0;
               end else begin
                  cnt_en     = 1'b1;
                  shadow_wr  = (sel != LAST_SLOT);
                  frame_done = (sel == LAST_SLOT);
               end
            end
         end
         default: state_nxt = HUNT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= HUNT;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_SLOTS - 1; i++) begin
            shadow[i] <= '0;
         end
      end else if (shadow_wr) begin
         shadow[wr_idx] <= din;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y0    <= '0;
         y1    <= '0;
         y2    <= '0;
         y3    <= '0;
         y4    <= '0;
         y5    <= '0;
         y6    <= '0;
         y7    <= '0;
         valid <= 1'b0;
      end else begin
         valid <= frame_done;
         if (frame_done) begin
            y0 <= shadow[0];
            y1 <= shadow[1];
            y2 <= shadow[2];
            y3 <= shadow[3];
            y4 <= shadow[4];
            y5 <= shadow[5];
            y6 <= shadow[6];
            y7 <= din;
         end
      end
   end

`ifdef DEMUX_SYNC_CHECK_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_err <= 1'b0;
      end else begin
         sync_err <= resync;
      end
   end
`else
   assign sync_err = 1'b0;
`endif

   assign locked = (state == RUN);

endmodule

// File: tb/tb_demux_1to8_tdm.sv
// Directed-vector bench for demux_1to8_tdm (W=4; single-bit tests use din[0]).
module tb_demux_1to8_tdm;
   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         en;
   logic         frame;
   logic [W-1:0] din;
   logic [W-1:0] y0, y1, y2, y3, y4, y5, y6, y7;
   logic         valid;
   logic [2:0]   sel;
   logic         locked;
   logic         sync_err;

   int n_cmp = 0;
   int n_err = 0;
   int vcnt;
   int ecnt;
   logic lock_seen;
   logic [7:0] pat;

   demux_1to8_tdm #(.W(W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .frame    (frame),
      .din      (din),
      .y0       (y0),
      .y1       (y1),
      .y2       (y2),
      .y3       (y3),
      .y4       (y4),
      .y5       (y5),
      .y6       (y6),
      .y7       (y7),
      .valid    (valid),
      .sel      (sel),
      .locked   (locked),
      .sync_err (sync_err)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] ybits();
      return {y7[0], y6[0], y5[0], y4[0], y3[0], y2[0], y1[0], y0[0]};
   endfunction

   function automatic logic [31:0] yfull();
      return {y7, y6, y5, y4, y3, y2, y1, y0};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Inputs applied 1 time unit after an edge, outputs sampled 1 unit after the next.
   task automatic step(input logic e, input logic f, input logic [W-1:0] d);
      en    = e;
      frame = f;
      din   = d;
      @(posedge clk);
      #1;
      vcnt += int'(valid);
      ecnt += int'(sync_err);
   endtask

   task automatic do_reset();
      en    = 1'b0;
      frame = 1'b0;
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      #1;
   endtask

   task automatic send_frame(input logic [7:0] bits);
      for (int k = 0; k < 8; k++) begin
         step(1'b1, k == 0, W'(bits[k]));
      end
   endtask

   initial begin
      rst_n = 1'b0;
      en    = 1'b0;
      frame = 1'b0;
      din   = '0;
      vcnt  = 0;
      ecnt  = 0;
      #1;
      chk("rst_y", yfull(), 32'h0);
      chk("rst_valid", 32'(valid), 32'h0);
      chk("rst_locked", 32'(locked), 32'h0);
      chk("rst_sel", 32'(sel), 32'h0);
      chk("rst_sync_err", 32'(sync_err), 32'h0);
      #2;
      rst_n = 1'b1;

      // Basic frame 1,0,1,1,0,0,1,0
      pat  = 8'h4D;
      vcnt = 0;
      for (int k = 0; k < 8; k++) begin
         step(1'b1, k == 0, W'(pat[k]));
         if (k == 0) begin
            chk("t1_locked", 32'(locked), 32'h1);
            chk("t1_sel1", 32'(sel), 32'h1);
         end
         if (k == 6) chk("t1_partial_y", yfull(), 32'h0);
      end
      chk("t1_valid", 32'(valid), 32'h1);
      chk("t1_y", 32'(ybits()), 32'h4D);
      step(1'b0, 1'b0, '0);
      chk("t1_valid_drop", 32'(valid), 32'h0);
      chk("t1_vcnt", 32'(vcnt), 32'h1);
      chk("t1_y_hold", 32'(ybits()), 32'h4D);

      // Same frame with en=0 gaps (frame=1 during gaps must be ignored)
      do_reset();
      vcnt = 0;
      for (int k = 0; k < 8; k++) begin
         step(1'b1, k == 0, W'(pat[k]));
         if (k == 2 || k == 5) begin
            step(1'b0, 1'b1, W'(1));
            chk("t2_sel_gap", 32'(sel), 32'(k + 1));
         end
      end
      chk("t2_y", 32'(ybits()), 32'h4D);
      step(1'b0, 1'b0, '0);
      chk("t2_vcnt", 32'(vcnt), 32'h1);

      // Toggling din, no frame marker: stays in HUNT
      do_reset();
      chk("t3_y_cleared", yfull(), 32'h0);
      vcnt      = 0;
      lock_seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         step(1'b1, 1'b0, W'(i[0]));
         lock_seen |= locked;
      end
      chk("t3_locked", 32'(lock_seen), 32'h0);
      chk("t3_y", yfull(), 32'h0);
      chk("t3_vcnt", 32'(vcnt), 32'h0);
      chk("t3_sel", 32'(sel), 32'h0);

      // Misplaced frame marker at slot 4 of second frame
      do_reset();
      send_frame(8'hFF);
      chk("t4_y_first", 32'(ybits()), 32'hFF);
      ecnt = 0;
      vcnt = 0;
      for (int k = 0; k < 4; k++) step(1'b1, k == 0, W'(1));
      step(1'b1, 1'b1, W'(1));
`ifdef DEMUX_SYNC_CHECK_EN
      chk("t4_sync_err", 32'(sync_err), 32'h1);
      chk("t4_sel_resync", 32'(sel), 32'h1);
      chk("t4_y_hold", 32'(ybits()), 32'hFF);
      chk("t4_locked", 32'(locked), 32'h1);
      step(1'b0, 1'b0, '0);
      chk("t4_sync_err_drop", 32'(sync_err), 32'h0);
      for (int k = 1; k < 8; k++) step(1'b1, 1'b0, '0);
      chk("t4_valid_after", 32'(valid), 32'h1);
      chk("t4_y_resync", 32'(ybits()), 32'h01);
      chk("t4_vcnt", 32'(vcnt), 32'h1);
`else
      chk("t4_sync_err", 32'(sync_err), 32'h0);
      chk("t4_sel", 32'(sel), 32'h5);
      chk("t4_valid_mid", 32'(valid), 32'h0);
      for (int k = 5; k < 8; k++) step(1'b1, 1'b0, W'(1));
      chk("t4_valid_done", 32'(valid), 32'h1);
      chk("t4_y", 32'(ybits()), 32'hFF);
      chk("t4_ecnt", 32'(ecnt), 32'h0);
`endif

      // Asynchronous reset mid-frame at slot 5
      do_reset();
      send_frame(pat);
      chk("t5_y_pre", 32'(ybits()), 32'h4D);
      for (int k = 0; k < 5; k++) step(1'b1, k == 0, W'(1));
      chk("t5_sel5", 32'(sel), 32'h5);
      en = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("t5_y_async", yfull(), 32'h0);
      chk("t5_sel_async", 32'(sel), 32'h0);
      chk("t5_locked_async", 32'(locked), 32'h0);
      chk("t5_valid_async", 32'(valid), 32'h0);
      chk("t5_sync_err_async", 32'(sync_err), 32'h0);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, W'(1));
      chk("t5_no_lock", 32'(locked), 32'h0);
      chk("t5_sel_hunt", 32'(sel), 32'h0);
      send_frame(8'h96);
      chk("t5_valid", 32'(valid), 32'h1);
      chk("t5_y", 32'(ybits()), 32'h96);

      // Back-to-back frames, continuous en, slot k carries k + 8*frame
      do_reset();
      ecnt = 0;
      for (int i = 0; i < 16; i++) begin
         step(1'b1, (i % 8) == 0, W'(i));
         chk("t6_valid", 32'(valid), 32'((i % 8) == 7));
         if (i == 7) chk("t6_y_f0", yfull(), 32'h76543210);
         if (i == 15) begin
            chk("t6_y_f1", yfull(), 32'hFEDCBA98);
            chk("t6_y7", 32'(y7), 32'd15);
         end
      end
      chk("t6_ecnt", 32'(ecnt), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
